alu_result_fifo: RTL and testbench
==================================

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of result entries (power of two, 2..16).
REQ-002 The block SHALL have parameter DROP_W, default 8, meaning the width of the saturating drop counter.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  meaning the reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  meaning an ALU result is presented.
REQ-006 The block SHALL have port in_ready  output  1  meaning the FIFO accepts a result this cycle.
REQ-007 The block SHALL have port in_y  input  16  meaning the ALU result y.
REQ-008 The block SHALL have port in_cout  input  1  meaning the ALU carry-out Cout.
REQ-009 The block SHALL have port in_select  input  5  meaning the ALU opcode that produced the result.
REQ-010 The block SHALL have port out_valid  output  1  meaning the head entry is valid.
REQ-011 The block SHALL have port out_ready  input  1  meaning the consumer takes the head entry.
REQ-012 The block SHALL have ports out_y  output  16, out_cout  output  1 and out_select  output  5, meaning the head entry fields.
REQ-013 The block SHALL have ports out_zero  output  1 and out_neg  output  1, meaning the head-entry flags (see Configuration).
REQ-014 The block SHALL have port count  output  $clog2(DEPTH)+1  meaning the current occupancy.
REQ-015 The block SHALL have port drop_cnt  output  DROP_W  meaning the number of results offered while full.

Function
REQ-016 A push SHALL occur on a cycle with in_valid=1 and in_ready=1; the fields {in_y, in_cout, in_select} SHALL be written at the write pointer.
REQ-017 A pop SHALL occur on a cycle with out_valid=1 and out_ready=1; the read pointer SHALL advance.
REQ-018 in_ready SHALL be 1 exactly when count<DEPTH, registered-state-derived, with no combinational path from out_ready.
REQ-019 out_valid SHALL be 1 exactly when count>0, and out_* SHALL present the entry at the read pointer.
REQ-020 Latency SHALL be one cycle: an entry pushed at edge N SHALL be visible with out_valid=1 after edge N, with no same-cycle bypass.
REQ-021 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-022 When full, push SHALL be blocked even if a pop occurs in the same cycle.
REQ-023 Pointers SHALL wrap modulo DEPTH.
REQ-024 out_* fields SHALL be held stable while out_valid=1 and out_ready=0.
REQ-025 Each cycle with in_valid=1 and in_ready=0 SHALL increment drop_cnt, which SHALL saturate at 2^DROP_W-1.
REQ-026 A pop on empty and a push on full SHALL be impossible and SHALL leave the state unchanged.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear the pointers, count and drop_cnt, and force out_valid=0 and in_ready=1, including mid-transfer.
REQ-028 out_y, out_cout, out_select, out_zero and out_neg SHALL read 0 while count=0; storage contents need not be reset.
REQ-029 After rst_n deasserts, the first push SHALL be accepted on the first rising edge.

Configuration
REQ-030 With macro ALU_RESULT_FLAGS_EN defined, the block SHALL compute zero=(y==0) and neg=y[15] at push time, store them per entry, and present them on out_zero and out_neg.
REQ-031 Without ALU_RESULT_FLAGS_EN, out_zero and out_neg SHALL be tied to 0 and no flag storage SHALL be built.

Verification
REQ-032 Single transfer: after reset, push y=16'hFFFF, cout=0, select=5'b00000 with out_ready=1 -> out_valid=1 the next cycle with the same fields, neg=1 and zero=0 (flags enabled), then count=0.
REQ-033 Fill and drop: push 6 results with out_ready=0 (DEPTH=4) -> in_ready=0 after the 4th push, count=4, drop_cnt=2, and the entries are popped in order.
REQ-034 Full plus pop: when full, hold in_valid=1 and pulse out_ready for 1 cycle -> one pop, no push that cycle, count=3, then a push the next cycle restores count=4.
REQ-035 Wrap and simultaneous: with continuous push and pop for 10 results with select 0..9 -> count stays at 1, the output order is 0..9 and the pointers wrap cleanly.
REQ-036 Reset mid-operation: with count=3 and drop_cnt=5, assert rst_n=0 between clock edges -> count=0, drop_cnt=0, out_valid=0 and in_ready=1 immediately.
REQ-037 Flags: push y=16'h0000, cout=1 -> out_zero=1 and out_neg=0 with the macro defined, and both 0 with the macro undefined.

Source files
------------

// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//   Small synchronous FIFO that buffers ALU results {y, cout, select} between
//   the ALU and a downstream consumer, with a valid/ready handshake on both
//   sides and a saturating counter of results offered while the FIFO is full.
//
//   Optional feature macro: ALU_RESULT_FLAGS_EN
//     defined   -> zero/neg flags are computed at push time, stored per entry
//                  and presented on out_zero / out_neg.
//     undefined -> out_zero / out_neg are tied low, no flag storage exists.
//
// Parameters
//   DEPTH   number of entries (power of two, 2..16)
//   DROP_W  width of the saturating drop counter
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   in_valid/in_ready               producer handshake
//   in_y, in_cout, in_select        ALU result fields
//   out_valid/out_ready             consumer handshake
//   out_y, out_cout, out_select     head entry fields (0 while empty)
//   out_zero, out_neg               head entry flags (0 while empty/disabled)
//   count                           current occupancy
//   drop_cnt                        results offered while full (saturating)
// -----------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_y,
    input  logic                     in_cout,
    input  logic [4:0]               in_select,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_y,
    output logic                     out_cout,
    output logic [4:0]               out_select,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int                AW         = $clog2(DEPTH);
    localparam int                CW         = AW + 1;
    localparam logic [CW-1:0]     DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0]     CNT_ONE_C  = CW'(1);
    localparam logic [AW-1:0]     PTR_ONE_C  = AW'(1);
    localparam logic [DROP_W-1:0] DROP_ONE_C = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_MAX_C = {DROP_W{1'b1}};

    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_nxt_s;
    logic [DROP_W-1:0] drop_cnt_r;

    logic              in_ready_s;
    logic              out_valid_s;
    logic              push_s;
    logic              pop_s;

    logic [15:0]       y_mem_r      [DEPTH];
    logic              cout_mem_r   [DEPTH];
    logic [4:0]        select_mem_r [DEPTH];

    // Handshake qualifiers come only from the registered occupancy, so a full
    // FIFO refuses a push even when a pop happens in the same cycle.
    assign in_ready_s  = (count_r < DEPTH_C);
    assign out_valid_s = (count_r != {CW{1'b0}});
    assign push_s      = in_valid & in_ready_s;
    assign pop_s       = out_valid_s & out_ready;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign count     = count_r;
    assign drop_cnt  = drop_cnt_r;

    // Next occupancy: simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            drop_cnt_r <= {DROP_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;   // wraps modulo DEPTH
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r <= count_nxt_s;
            if (in_valid && !in_ready_s && (drop_cnt_r != DROP_MAX_C)) begin
                drop_cnt_r <= drop_cnt_r + DROP_ONE_C;
            end
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            y_mem_r[wr_ptr_r]      <= in_y;
            cout_mem_r[wr_ptr_r]   <= in_cout;
            select_mem_r[wr_ptr_r] <= in_select;
        end
    end

`ifdef ALU_RESULT_FLAGS_EN
    logic zero_mem_r [DEPTH];
    logic neg_mem_r  [DEPTH];

    // Flags are derived once at push time and stored alongside the entry.
    always_ff @(posedge clk) begin
        if (push_s) begin
            zero_mem_r[wr_ptr_r] <= (in_y == 16'h0000);
            neg_mem_r[wr_ptr_r]  <= in_y[15];
        end
    end

    // Head flags, forced low while empty.
    always_comb begin
        out_zero = 1'b0;
        out_neg  = 1'b0;
        if (out_valid_s) begin
            out_zero = zero_mem_r[rd_ptr_r];
            out_neg  = neg_mem_r[rd_ptr_r];
        end else begin
            out_zero = 1'b0;
            out_neg  = 1'b0;
        end
    end
`else
    assign out_zero = 1'b0;
    assign out_neg  = 1'b0;
`endif

    // Head entry fields, forced to zero while empty so stale storage never
    // leaks out; stable while stalled because rd_ptr_r only moves on a pop.
    always_comb begin
        out_y      = 16'h0000;
        out_cout   = 1'b0;
        out_select = 5'b00000;
        if (out_valid_s) begin
            out_y      = y_mem_r[rd_ptr_r];
            out_cout   = cout_mem_r[rd_ptr_r];
            out_select = select_mem_r[rd_ptr_r];
        end else begin
            out_y      = 16'h0000;
            out_cout   = 1'b0;
            out_select = 5'b00000;
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_alu_result_fifo
//   Scoreboard bench for alu_result_fifo (DEPTH=4, DROP_W=8). Every pushed
//   result is queued; every pop is compared against the queue head. Occupancy
//   and drop counts come from the bench's own bookkeeping.
// -----------------------------------------------------------------------------
module tb_alu_result_fifo;

    localparam int DEPTH  = 4;
    localparam int DROP_W = 8;
    localparam int DROP_MAX = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_y = 16'h0000;
    logic        in_cout = 1'b0;
    logic [4:0]  in_select = 5'b00000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_y;
    logic        out_cout;
    logic [4:0]  out_select;
    logic        out_zero;
    logic        out_neg;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;

    typedef struct packed {
        logic [15:0] y;
        logic        cout;
        logic [4:0]  sel;
    } ent_t;

    ent_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   m_drop      = 0;

    alu_result_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_y       (in_y),
        .in_cout    (in_cout),
        .in_select  (in_select),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_cout   (out_cout),
        .out_select (out_select),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .count      (count),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // One clock of stimulus. Entered 1 time unit after a rising edge; outputs
    // are sampled mid-cycle, the scoreboard is updated, and it returns 1 unit
    // after the next rising edge.
    task automatic drive_cycle(input logic v, input logic [15:0] y, input logic c,
                               input logic [4:0] s, input logic ordy);
        ent_t exp;
        logic exp_z;
        logic exp_n;
        logic push;
        logic pop;
        in_valid  = v;
        in_y      = y;
        in_cout   = c;
        in_select = s;
        out_ready = ordy;
        #3;
        vectors++;
        if (in_ready !== (sb_q.size() < DEPTH)) begin
            miscompares++;
            $display("FAIL in_ready: got %b expected %b", in_ready, (sb_q.size() < DEPTH));
        end
        vectors++;
        if (out_valid !== (sb_q.size() > 0)) begin
            miscompares++;
            $display("FAIL out_valid: got %b expected %b", out_valid, (sb_q.size() > 0));
        end
        pop  = (sb_q.size() > 0) && ordy;
        push = v && (sb_q.size() < DEPTH);
        if (sb_q.size() > 0) begin
            exp = sb_q[0];
            vectors++;
            if ({out_y, out_cout, out_select} !== exp) begin
                miscompares++;
                $display("FAIL head_entry: got y=%h c=%b s=%h expected y=%h c=%b s=%h",
                         out_y, out_cout, out_select, exp.y, exp.cout, exp.sel);
            end
`ifdef ALU_RESULT_FLAGS_EN
            exp_z = (exp.y == 16'h0000);
            exp_n = exp.y[15];
`else
            exp_z = 1'b0;
            exp_n = 1'b0;
`endif
            vectors++;
            if ({out_zero, out_neg} !== {exp_z, exp_n}) begin
                miscompares++;
                $display("FAIL head_flags: got z=%b n=%b expected z=%b n=%b",
                         out_zero, out_neg, exp_z, exp_n);
            end
        end else begin
            vectors++;
            if ({out_y, out_cout, out_select, out_zero, out_neg} !== 24'h000000) begin
                miscompares++;
                $display("FAIL empty_fields: got y=%h c=%b s=%h z=%b n=%b expected all 0",
                         out_y, out_cout, out_select, out_zero, out_neg);
            end
        end
        if (pop) begin
            exp = sb_q.pop_front();
        end
        if (v && !push && (m_drop < DROP_MAX)) begin
            m_drop++;
        end
        if (push) begin
            sb_q.push_back({y, c, s});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({count, drop_cnt, out_valid, in_ready} !== {3'd0, 8'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_state: got count=%0d drop=%0d ov=%b ir=%b expected 0 0 0 1",
                     count, drop_cnt, out_valid, in_ready);
        end
        vectors++;
        if ({out_y, out_cout, out_select, out_zero, out_neg} !== 24'h000000) begin
            miscompares++;
            $display("FAIL reset_fields: got y=%h expected 0", out_y);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        drive_cycle(1'b1, 16'hFFFF, 1'b0, 5'b00000, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || count !== 3'd1) begin
            miscompares++;
            $display("FAIL single_latency: got ov=%b count=%0d expected 1 1", out_valid, count);
        end
`ifdef ALU_RESULT_FLAGS_EN
        vectors++;
        if ({out_neg, out_zero} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_flags: got n=%b z=%b expected 1 0", out_neg, out_zero);
        end
`endif
        drive_cycle(1'b0, 16'h0000, 1'b0, 5'b00000, 1'b1);
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drain: got count=%0d ov=%b expected 0 0", count, out_valid);
        end
    endtask

    task automatic test_fill_drop();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 16'h1000 + 16'(i), 1'(i), 5'(i), 1'b0);
            if (i == 3) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fill_in_ready: got %b expected 0", in_ready);
                end
            end
        end
        vectors++;
        if (count !== 3'd4 || drop_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL fill_drop: got count=%0d drop=%0d expected 4 2", count, drop_cnt);
        end
    endtask

    task automatic test_full_pop();
        drive_cycle(1'b1, 16'h2000, 1'b0, 5'd10, 1'b1);
        vectors++;
        if (count !== 3'd3 || drop_cnt !== 8'd3) begin
            miscompares++;
            $display("FAIL full_pop: got count=%0d drop=%0d expected 3 3", count, drop_cnt);
        end
        drive_cycle(1'b1, 16'h2001, 1'b1, 5'd11, 1'b0);
        vectors++;
        if (count !== 3'd4) begin
            miscompares++;
            $display("FAIL full_refill: got count=%0d expected 4", count);
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 16'h0000, 1'b0, 5'd0, 1'b1);
        end
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("FAIL full_drain: got count=%0d expected 0", count);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, 16'h3000 + 16'(i), 1'(i), 5'(i), 1'b1);
            vectors++;
            if (count !== 3'd1) begin
                miscompares++;
                $display("FAIL b2b_count[%0d]: got %0d expected 1", i, count);
            end
        end
        drive_cycle(1'b0, 16'h0000, 1'b0, 5'd0, 1'b1);
        vectors++;
        if (count !== 3'd0 || sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: got count=%0d expected 0", count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 16'h4000 + 16'(i), 1'b0, 5'(i + 16), 1'b0);
        end
        drive_cycle(1'b0, 16'h0000, 1'b0, 5'd0, 1'b1);
        vectors++;
        if (count !== 3'd3 || drop_cnt !== 8'd5) begin
            miscompares++;
            $display("FAIL mid_setup: got count=%0d drop=%0d expected 3 5", count, drop_cnt);
        end
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({count, drop_cnt, out_valid, in_ready} !== {3'd0, 8'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_reset: got count=%0d drop=%0d ov=%b ir=%b expected 0 0 0 1",
                     count, drop_cnt, out_valid, in_ready);
        end
        sb_q.delete();
        m_drop = 0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_flags();
        drive_cycle(1'b1, 16'h0000, 1'b1, 5'd3, 1'b0);
`ifdef ALU_RESULT_FLAGS_EN
        vectors++;
        if ({out_zero, out_neg} !== 2'b10) begin
            miscompares++;
            $display("FAIL flags_zero: got z=%b n=%b expected 1 0", out_zero, out_neg);
        end
`else
        vectors++;
        if ({out_zero, out_neg} !== 2'b00) begin
            miscompares++;
            $display("FAIL flags_off: got z=%b n=%b expected 0 0", out_zero, out_neg);
        end
`endif
        drive_cycle(1'b1, 16'h8001, 1'b0, 5'd4, 1'b1);
        drive_cycle(1'b0, 16'h0000, 1'b0, 5'd0, 1'b1);
    endtask

    task automatic test_drop_saturate();
        for (int i = 0; i < 264; i++) begin
            drive_cycle(1'b1, 16'h5000 + 16'(i), 1'b0, 5'(i), 1'b0);
        end
        vectors++;
        if (drop_cnt !== 8'(DROP_MAX) || drop_cnt !== 8'(m_drop)) begin
            miscompares++;
            $display("FAIL drop_saturate: got %0d expected %0d", drop_cnt, DROP_MAX);
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 16'h0000, 1'b0, 5'd0, 1'b1);
        end
        vectors++;
        if (drop_cnt !== 8'(DROP_MAX) || count !== 3'd0) begin
            miscompares++;
            $display("FAIL drop_hold: got drop=%0d count=%0d expected 255 0", drop_cnt, count);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_fill_drop();
        test_full_pop();
        test_back_to_back();
        test_reset_mid();
        test_flags();
        test_drop_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
